led_frame_receiver: RTL
=======================

// Module: led_frame_receiver
// PURPOSE
//   Serial-in/parallel-out receiver for the LED shift frame (sdi + start/str framing).
//   Deserialises WIDTH bits per frame and latches them to led_out only when str closes a full frame.
//   Checks framing and flags errors; serves as the sink/checker at the far end of the LED serial link.
// PARAMETERS
//   WIDTH      16  bits per frame; legal range 2..32
//   MSB_FIRST  1   1: first bit lands in led_out[WIDTH-1]; 0: first bit lands in led_out[0]
// PORTS
//   clk         in   1      system clock; all sampling on posedge
//   rst         in   1      asynchronous reset, active-high
//   sdi         in   1      serial data, one bit per clk cycle
//   start       in   1      high during the cycle of bit 0 of a frame
//   str         in   1      high during the cycle of bit WIDTH-1 (strobe/latch)
//   led_out     out  WIDTH  last complete, validly framed word
//   frame_valid out  1      1-cycle pulse: led_out was just updated
//   frame_err   out  1      1-cycle pulse: framing violation detected
//   busy        out  1      1 while in SHIFT
//   err_cnt     out  8      saturating count of frame_err pulses
// BEHAVIOUR
//   Reset: state=IDLE, bit index=0, shift reg=0, led_out=0, frame_valid=0, frame_err=0, busy=0, err_cnt=0.
//   Inputs are sampled on posedge clk. The sender updates start/str on negedge, so no synchroniser is used.
//   States: IDLE, SHIFT. busy = (state==SHIFT), registered.
//   IDLE:
//     - start=1: capture sdi as bit 0, idx<=1, go to SHIFT.
//     - str=1 with start=0: frame_err pulse, stay in IDLE.
//     - Otherwise: hold.
//   SHIFT, checked in priority order each edge:
//     1) start=1 (resync): frame_err pulse, discard partial word, capture sdi as the new bit 0, idx<=1, stay in SHIFT.
//        This also applies when str is high in the same cycle.
//     2) idx<WIDTH-1 and str=1 (early strobe): frame_err pulse, discard, go to IDLE.
//     3) idx==WIDTH-1 and str=1: led_out <= assembled word including this sdi, frame_valid pulse, go to IDLE.
//     4) idx==WIDTH-1 and str=0 (missing strobe): frame_err pulse, discard, go to IDLE.
//     5) Otherwise: shift in sdi, idx<=idx+1.
//   Back-to-back frames: after case 3 the FSM is in IDLE, so start on the next cycle begins a new frame.
//     No dead cycle; a continuous stream gives frame_valid every WIDTH cycles.
//   Latency: led_out and frame_valid are updated on the same edge that samples bit WIDTH-1.
//     They are visible in the following cycle.
//   led_out holds its value across errors and idle time. It changes only in case 3 or on reset.
//   Assembly with MSB_FIRST=1: sh <= {sh[WIDTH-2:0], sdi}. With MSB_FIRST=0: sh <= {sdi, sh[WIDTH-1:1]}.
//   idx is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
//   err_cnt increments on each frame_err pulse and saturates at 8'hFF.
//   frame_valid and frame_err are never high in the same cycle.
//   rst asserted mid-frame: everything returns to reset values immediately.
//     After release, the FSM waits in IDLE for the next start; a partial frame is never latched.
// TESTING
//   1 Frame 16'hA5C3, MSB first, start@bit0, str@bit15 -> led_out=16'hA5C3 one cycle later; frame_valid one pulse; err_cnt=0.
//   2 Frames 16'h1234 then 16'hFFFF back-to-back, no gap -> two frame_valid pulses exactly 16 cycles apart; led_out ends at 16'hFFFF.
//   3 str at bit 9 -> frame_err pulse, led_out unchanged, busy=0; next good frame 16'h00FF latches normally.
//   4 start re-asserted at bit 6, then a full frame 16'h8001 -> one frame_err, then led_out=16'h8001, err_cnt=1.
//   5 No str at bit 15 -> frame_err, led_out unchanged; 300 such errors -> err_cnt=8'hFF, saturated.
//   6 rst pulsed at bit 10 of frame 16'hBEEF -> all outputs 0, no frame_valid; next frame 16'h0F0F latches normally.

Source files
------------

// File: rtl/led_frame_receiver.sv
// Serial-in/parallel-out receiver for the LED shift link: deserialises WIDTH bits
// framed by start/str, latches complete frames to led_out and flags framing errors.
module led_frame_receiver #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdi,
  input  logic             start,
  input  logic             str,
  output logic [WIDTH-1:0] led_out,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [7:0]       err_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sh;
  logic             err_evt;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    if (MSB_FIRST) return {s[WIDTH-2:0], b};
    else           return {b, s[WIDTH-1:1]};
  endfunction

  // Framing violations: stray strobe in IDLE; resync, early strobe or missing strobe in SHIFT.
  always_comb begin
    err_evt = 1'b0;
    if (state == IDLE) err_evt = str && !start;
    else               err_evt = start || (str && (idx != LAST)) || (!str && (idx == LAST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      sh          <= '0;
      led_out     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= err_evt;
      if (err_evt && (err_cnt != '1)) err_cnt <= err_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            sh    <= shift_in('0, sdi);
            idx   <= IDX_W'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (start) begin
            sh  <= shift_in('0, sdi);
            idx <= IDX_W'(1);
          end else if (str || (idx == LAST)) begin
            if (str && (idx == LAST)) begin
              led_out     <= shift_in(sh, sdi);
              frame_valid <= 1'b1;
            end
            sh    <= '0;
            idx   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sh  <= shift_in(sh, sdi);
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
